if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/ariane_pkg.sv | 20 ++
 rtl/if_fetch_unit_if.sv | 30 +++
 rtl/if_fetch_unit_slot_mask.sv | 28 ++
 rtl/if_fetch_unit.sv | 122 ++++++++++++
 tb/tb_if_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ariane_pkg.sv
// Shared fetch-path types: branch prediction record and the bundle handed to the fetch FIFO.
package ariane_pkg;

   localparam int unsigned FETCH_WIDTH = 4;

   typedef struct packed {
      logic        valid;
      logic        predict_taken;
      logic [63:0] predict_address;
   } branchpredict_sbe_t;

   typedef struct packed {
      logic [63:0]                  address;
      logic [FETCH_WIDTH-1:0][31:0] instr;
      logic [FETCH_WIDTH-1:0]       slot_mask;
      branchpredict_sbe_t           bp;
      logic                         ex_valid;
   } fetch_bundle_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// I-cache request/response bus between the fetch unit (master) and the instruction cache (slave).
interface if_fetch_unit_if;
   import ariane_pkg::*;

   logic                        icache_req;
   logic [63:0]                 icache_addr;
   logic                        icache_gnt;
   logic                        icache_rvalid;
   logic [FETCH_WIDTH*32-1:0]   icache_rdata;
   logic                        icache_ex;

   modport master (
      output icache_req,
      output icache_addr,
      input  icache_gnt,
      input  icache_rvalid,
      input  icache_rdata,
      input  icache_ex
   );

   modport slave (
      input  icache_req,
      input  icache_addr,
      output icache_gnt,
      output icache_rvalid,
      output icache_rdata,
      output icache_ex
   );

endinterface

// File: rtl/if_fetch_unit_slot_mask.sv
// Valid-slot mask for one fetch bundle: slots from the PC's word offset upward,
// truncated after a predicted-taken branch unless the fetch faulted.
module fetch_slot_mask
   import ariane_pkg::*;
(
   input  logic [1:0]             start_i,
   input  logic                   taken_i,
   input  logic [1:0]             taken_slot_i,
   input  logic                   ex_i,
   output logic [FETCH_WIDTH-1:0] mask_o
);

   localparam logic [FETCH_WIDTH-1:0] ALL_SLOTS = '1;

   logic [FETCH_WIDTH-1:0] base_mask;
   logic [FETCH_WIDTH-1:0] keep_mask;

   always_comb begin
      base_mask = ALL_SLOTS << start_i;
      keep_mask = ALL_SLOTS >> (2'd3 - taken_slot_i);
      mask_o    = base_mask;
      // A taken branch before the start slot cannot belong to this fetch; ignore it.
      if (taken_i && !ex_i && (taken_slot_i >= start_i)) begin
         mask_o = base_mask & keep_mask;
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: one outstanding I-cache request, a single output bundle register,
// and flush handling that drains a granted request before fetching again.
//
//  state       | meaning
//  IDLE        | no request in flight; may accept a new fetch address
//  WAIT_GNT    | request presented to the I-cache, waiting for grant
//  WAIT_RVALID | granted, waiting for the response data
//  KILL        | flushed after grant; next response is dropped
module if_fetch_unit
   import ariane_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               flush_i,
   input  logic [63:0]        fetch_address_i,
   input  logic               fetch_valid_i,
   input  logic [1:0]         which_branch_taken_i,
   input  branchpredict_sbe_t branch_predict_i,
   output logic               if_ready_o,
   if_fetch_unit_if.master    icache,
   output fetch_bundle_t      fetch_entry_o,
   output logic               fetch_entry_valid_o,
   input  logic               fetch_entry_ready_i
);

   typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID, KILL} state_e;

   state_e             state_q, state_d;
   logic [63:0]        addr_q, addr_d;
   branchpredict_sbe_t bp_q, bp_d;
   logic [1:0]         wbt_q, wbt_d;
   logic               out_valid_q, out_valid_d;
   fetch_bundle_t      entry_q, entry_d;
   logic [FETCH_WIDTH-1:0] slot_mask;

   // Only accept when the output register will be free by the time the response lands.
   assign if_ready_o          = (state_q == IDLE) && !flush_i && (!out_valid_q || fetch_entry_ready_i);
   assign icache.icache_req   = (state_q == WAIT_GNT);
   assign icache.icache_addr  = {addr_q[63:4], 4'h0};
   assign fetch_entry_o       = entry_q;
   assign fetch_entry_valid_o = out_valid_q;

   fetch_slot_mask u_slot_mask (
      .start_i      (addr_q[3:2]),
      .taken_i      (bp_q.valid && bp_q.predict_taken),
      .taken_slot_i (wbt_q),
      .ex_i         (icache.icache_ex),
      .mask_o       (slot_mask)
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      bp_d        = bp_q;
      wbt_d       = wbt_q;
      entry_d     = entry_q;
      out_valid_d = out_valid_q && !fetch_entry_ready_i;

      unique case (state_q)
         IDLE: begin
            if (fetch_valid_i && if_ready_o) begin
               addr_d  = fetch_address_i;
               bp_d    = branch_predict_i;
               wbt_d   = which_branch_taken_i;
               state_d = WAIT_GNT;
            end
         end
         WAIT_GNT: begin
            // Once granted the cache owes a response, so a flush must drain it in KILL.
            if (icache.icache_gnt) begin
               state_d = flush_i ? KILL : WAIT_RVALID;
            end else if (flush_i) begin
               state_d = IDLE;
            end
         end
         WAIT_RVALID: begin
            if (icache.icache_rvalid) begin
               state_d = IDLE;
               if (!flush_i) begin
                  out_valid_d       = 1'b1;
                  entry_d.address   = addr_q;
                  entry_d.instr     = icache.icache_rdata;
                  entry_d.slot_mask = slot_mask;
                  entry_d.bp        = bp_q;
                  entry_d.ex_valid  = icache.icache_ex;
               end
            end else if (flush_i) begin
               state_d = KILL;
            end
         end
         KILL: begin
            if (icache.icache_rvalid) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (flush_i) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         bp_q        <= '0;
         wbt_q       <= '0;
         out_valid_q <= 1'b0;
         entry_q     <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         bp_q        <= bp_d;
         wbt_q       <= wbt_d;
         out_valid_q <= out_valid_d;
         entry_q     <= entry_d;
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_if_fetch_unit;
   import ariane_pkg::*;

   logic               clk_i = 1'b0;
   logic               rst_ni = 1'b0;
   logic               flush_i;
   logic [63:0]        fetch_address_i;
   logic               fetch_valid_i;
   logic [1:0]         which_branch_taken_i;
   branchpredict_sbe_t branch_predict_i;
   logic               if_ready_o;
   fetch_bundle_t      fetch_entry_o;
   logic               fetch_entry_valid_o;
   logic               fetch_entry_ready_i;

   if_fetch_unit_if icache_bus ();

   if_fetch_unit dut (
      .clk_i                (clk_i),
      .rst_ni               (rst_ni),
      .flush_i              (flush_i),
      .fetch_address_i      (fetch_address_i),
      .fetch_valid_i        (fetch_valid_i),
      .which_branch_taken_i (which_branch_taken_i),
      .branch_predict_i     (branch_predict_i),
      .if_ready_o           (if_ready_o),
      .icache               (icache_bus),
      .fetch_entry_o        (fetch_entry_o),
      .fetch_entry_valid_o  (fetch_entry_valid_o),
      .fetch_entry_ready_i  (fetch_entry_ready_i)
   );

   initial forever #5 clk_i = ~clk_i;

   int vectors = 0;
   int miscompares = 0;

   // Transaction-level model: is a fetch in progress, has the cache committed to answer,
   // and has a flush condemned the answer.
   bit                 m_busy, m_granted, m_doomed, m_out_valid;
   logic [63:0]        m_addr;
   branchpredict_sbe_t m_bp;
   logic [1:0]         m_wbt;
   fetch_bundle_t      m_out;

   localparam logic [31:0] WA = 32'hA0A0_0001, WB = 32'hB0B0_0002,
                           WC = 32'hC0C0_0003, WD = 32'hD0D0_0004;

   function automatic logic [3:0] model_mask(logic [63:0] a, branchpredict_sbe_t b,
                                             logic [1:0] w, logic ex);
      int start = int'(a[3:2]);
      bit taken = b.valid && b.predict_taken;
      logic [3:0] m;
      for (int i = 0; i < 4; i++)
         m[i] = (i >= start) && (ex || !taken || int'(w) < start || i <= int'(w));
      return m;
   endfunction

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_granted = 0; m_doomed = 0; m_out_valid = 0;
      m_addr = '0; m_bp = '0; m_wbt = '0; m_out = '0;
   endtask

   task automatic check_model();
      bit exp_ready = !m_busy && !flush_i && (!m_out_valid || fetch_entry_ready_i);
      bit exp_req   = m_busy && !m_granted;
      chk("if_ready", 512'(if_ready_o), 512'(exp_ready));
      chk("icache_req", 512'(icache_bus.icache_req), 512'(exp_req));
      if (exp_req) chk("icache_addr", 512'(icache_bus.icache_addr), 512'({m_addr[63:4], 4'h0}));
      chk("entry_valid", 512'(fetch_entry_valid_o), 512'(m_out_valid));
      if (m_out_valid) chk("entry", 512'(fetch_entry_o), 512'(m_out));
   endtask

   task automatic update_model();
      bit acc = !m_busy && !flush_i && (!m_out_valid || fetch_entry_ready_i) && fetch_valid_i;
      bit nov = m_out_valid && !fetch_entry_ready_i;
      if (!m_busy) begin
         if (acc) begin
            m_addr = fetch_address_i; m_bp = branch_predict_i; m_wbt = which_branch_taken_i;
            m_busy = 1; m_granted = 0; m_doomed = 0;
         end
      end else if (!m_granted) begin
         if (icache_bus.icache_gnt) begin
            m_granted = 1; m_doomed = flush_i;
         end else if (flush_i) begin
            m_busy = 0;
         end
      end else begin
         if (icache_bus.icache_rvalid) begin
            m_busy = 0;
            if (!m_doomed && !flush_i) begin
               nov             = 1;
               m_out.address   = m_addr;
               m_out.instr     = icache_bus.icache_rdata;
               m_out.slot_mask = model_mask(m_addr, m_bp, m_wbt, icache_bus.icache_ex);
               m_out.bp        = m_bp;
               m_out.ex_valid  = icache_bus.icache_ex;
            end
         end else if (flush_i) begin
            m_doomed = 1;
         end
      end
      if (flush_i) nov = 0;
      m_out_valid = nov;
   endtask

   task automatic idle();
      flush_i = 0; fetch_valid_i = 0; fetch_address_i = '0; which_branch_taken_i = '0;
      branch_predict_i = '0; fetch_entry_ready_i = 1;
      icache_bus.icache_gnt = 0; icache_bus.icache_rvalid = 0;
      icache_bus.icache_rdata = '0; icache_bus.icache_ex = 0;
   endtask

   task automatic settle();
      #1;
      check_model();
   endtask

   task automatic clk_edge();
      @(posedge clk_i);
      update_model();
      @(negedge clk_i);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      model_reset();
      @(negedge clk_i);
      #1;
      chk("rst_if_ready", 512'(if_ready_o), 512'(1'b1));
      chk("rst_req", 512'(icache_bus.icache_req), 512'(1'b0));
      chk("rst_valid", 512'(fetch_entry_valid_o), 512'(1'b0));
      @(negedge clk_i);
      rst_ni = 1;

      // Aligned-block fetch from a mid-block PC.
      idle(); fetch_valid_i = 1; fetch_address_i = 64'h8000_0008;
      settle(); clk_edge();
      fetch_valid_i = 0; icache_bus.icache_gnt = 1;
      settle();
      chk("t1_req", 512'(icache_bus.icache_req), 512'(1'b1));
      chk("t1_icache_addr", 512'(icache_bus.icache_addr), 512'(64'h8000_0000));
      clk_edge();
      icache_bus.icache_gnt = 0; icache_bus.icache_rvalid = 1;
      icache_bus.icache_rdata = {WD, WC, WB, WA};
      settle(); clk_edge();

      // Bundle held while the FIFO stalls; the next PC waits with a taken prediction.
      icache_bus.icache_rvalid = 0; fetch_entry_ready_i = 0;
      fetch_valid_i = 1; fetch_address_i = 64'h1000_0000;
      branch_predict_i.valid = 1; branch_predict_i.predict_taken = 1;
      branch_predict_i.predict_address = 64'h1000_0040; which_branch_taken_i = 2'd1;
      for (int k = 0; k < 5; k++) begin
         settle();
         chk("t1_valid", 512'(fetch_entry_valid_o), 512'(1'b1));
         chk("t1_addr", 512'(fetch_entry_o.address), 512'(64'h8000_0008));
         chk("t1_mask", 512'(fetch_entry_o.slot_mask), 512'(4'b1100));
         chk("t1_instr2", 512'(fetch_entry_o.instr[2]), 512'(WC));
         chk("stall_if_ready", 512'(if_ready_o), 512'(1'b0));
         clk_edge();
      end
      fetch_entry_ready_i = 1;
      settle();
      chk("release_accept", 512'(if_ready_o), 512'(1'b1));
      clk_edge();
      fetch_valid_i = 0; icache_bus.icache_gnt = 1;
      settle(); clk_edge();
      icache_bus.icache_gnt = 0; icache_bus.icache_rvalid = 1;
      icache_bus.icache_rdata = {$urandom, $urandom, $urandom, $urandom};
      settle(); clk_edge();
      icache_bus.icache_rvalid = 0;
      settle();
      chk("t2_valid", 512'(fetch_entry_valid_o), 512'(1'b1));
      chk("t2_mask", 512'(fetch_entry_o.slot_mask), 512'(4'b0011));
      clk_edge();

      // Flush while waiting for data: the late response must be swallowed.
      idle(); fetch_valid_i = 1; fetch_address_i = 64'h2000_0004;
      settle(); clk_edge();
      fetch_valid_i = 0; icache_bus.icache_gnt = 1;
      settle(); clk_edge();
      icache_bus.icache_gnt = 0; flush_i = 1;
      settle(); clk_edge();
      flush_i = 0;
      settle();
      chk("kill_if_ready_a", 512'(if_ready_o), 512'(1'b0));
      clk_edge();
      icache_bus.icache_rvalid = 1; icache_bus.icache_rdata = {WA, WB, WC, WD};
      settle();
      chk("kill_if_ready_b", 512'(if_ready_o), 512'(1'b0));
      clk_edge();
      icache_bus.icache_rvalid = 0;
      settle();
      chk("kill_if_ready_after", 512'(if_ready_o), 512'(1'b1));
      chk("kill_no_bundle", 512'(fetch_entry_valid_o), 512'(1'b0));
      clk_edge();

      // Faulting fetch keeps only the base mask.
      idle(); fetch_valid_i = 1; fetch_address_i = 64'h3000_000C;
      branch_predict_i.valid = 1; branch_predict_i.predict_taken = 1; which_branch_taken_i = 2'd3;
      settle(); clk_edge();
      fetch_valid_i = 0; icache_bus.icache_gnt = 1;
      settle(); clk_edge();
      icache_bus.icache_gnt = 0; icache_bus.icache_rvalid = 1; icache_bus.icache_ex = 1;
      settle(); clk_edge();
      icache_bus.icache_rvalid = 0; icache_bus.icache_ex = 0;
      settle();
      chk("ex_valid", 512'(fetch_entry_o.ex_valid), 512'(1'b1));
      chk("ex_mask", 512'(fetch_entry_o.slot_mask), 512'(4'b1000));
      clk_edge();

      // Asynchronous reset while a request is pending.
      idle(); fetch_valid_i = 1; fetch_address_i = 64'h4000_0010;
      settle(); clk_edge();
      fetch_valid_i = 0;
      settle();
      chk("pre_rst_req", 512'(icache_bus.icache_req), 512'(1'b1));
      rst_ni = 0;
      #1;
      chk("async_rst_req", 512'(icache_bus.icache_req), 512'(1'b0));
      chk("async_rst_valid", 512'(fetch_entry_valid_o), 512'(1'b0));
      chk("async_rst_ready", 512'(if_ready_o), 512'(1'b1));
      model_reset();
      @(negedge clk_i);
      rst_ni = 1;

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         flush_i                 = ($urandom_range(15) == 0);
         fetch_valid_i           = ($urandom_range(3) != 0);
         fetch_address_i         = {$urandom, $urandom};
         which_branch_taken_i    = 2'($urandom_range(3));
         branch_predict_i.valid  = $urandom_range(1) == 1;
         branch_predict_i.predict_taken   = $urandom_range(1) == 1;
         branch_predict_i.predict_address = {$urandom, $urandom};
         fetch_entry_ready_i     = ($urandom_range(3) != 0);
         icache_bus.icache_gnt   = $urandom_range(1) == 1;
         icache_bus.icache_rvalid = (m_busy && m_granted) ? ($urandom_range(2) == 0) : 1'b0;
         icache_bus.icache_rdata = {$urandom, $urandom, $urandom, $urandom};
         icache_bus.icache_ex    = ($urandom_range(7) == 0);
         settle();
         clk_edge();
      end

      idle();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
